// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_if
//  Purpose  : Bundles the hazard-detection inputs and the stage-register
//             enable/flush controls exchanged between the 5-stage MIPS
//             datapath and the hazard controller.
//  Modports : master - datapath side (drives hazard inputs, receives controls)
//             slave  - controller side (receives hazard inputs, drives controls)
//  Signals  : IFID_Rs/IFID_Rt/IFID_UsesRt   ID-stage source operands
//             IDEX_MemRead/IDEX_Rt          load in EX and its destination
//             ID_Jump, EX_BranchTaken       control-flow redirects
//             EX_MulDivStart                MULT/DIV entering EX
//             *_WriteEnable, *_Flush        stage register controls
//             Busy, StallCycles             status / performance counter
//  Revision : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        IFID_UsesRt;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic        ID_Jump;
  logic        EX_BranchTaken;
  logic        EX_MulDivStart;

  logic        PC_WriteEnable;
  logic        IFID_WriteEnable;
  logic        IFID_Flush;
  logic        IDEX_WriteEnable;
  logic        IDEX_Flush;
  logic        EXMEM_Flush;
  logic        Busy;
  logic [15:0] StallCycles;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
           ID_Jump, EX_BranchTaken, EX_MulDivStart,
    input  PC_WriteEnable, IFID_WriteEnable, IFID_Flush, IDEX_WriteEnable,
           IDEX_Flush, EXMEM_Flush, Busy, StallCycles
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IDEX_MemRead, IDEX_Rt,
           ID_Jump, EX_BranchTaken, EX_MulDivStart,
    output PC_WriteEnable, IFID_WriteEnable, IFID_Flush, IDEX_WriteEnable,
           IDEX_Flush, EXMEM_Flush, Busy, StallCycles
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard controller for the 5-stage MIPS core. Resolves load-use
//             stalls, jump/branch squashes and multi-cycle MULT/DIV occupancy
//             of EX, and counts stall cycles (saturating) for perf monitoring.
//  Ports    : Clock - clock, all state changes on rising edge
//             Reset - synchronous, active-high reset
//             hz    - pipeline_hazard_ctrl_if.slave (hazard inputs in,
//                     stage-register enables/flushes and status out)
//  Params   : MULDIV_CYCLES - cycles a MULT/DIV occupies EX (2..256)
//             CNT_W         - occupancy down-counter width
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  wire logic              Clock,
  input  wire logic              Reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_MULDIV = 1'b1
  } state_t;

  // The start cycle is already a freeze cycle, and the release cycle sits at
  // Count==0, so the counter is loaded with two less than the occupancy.
  localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(MULDIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      c_STALL_MAX = 16'hFFFF;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic [15:0]      r_stall_cycles;

  logic w_load_use;
  logic w_pc_we;
  logic w_ifid_we;
  logic w_ifid_flush;
  logic w_idex_we;
  logic w_idex_flush;
  logic w_exmem_flush;

  // Register 0 is hardwired, so a load into $zero never creates a hazard.
  assign w_load_use = hz.IDEX_MemRead && (hz.IDEX_Rt != 5'd0) &&
                      ((hz.IDEX_Rt == hz.IFID_Rs) ||
                       (hz.IFID_UsesRt && (hz.IDEX_Rt == hz.IFID_Rt)));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_RUN;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_pc_we       = 1'b1;
    w_ifid_we     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_we     = 1'b1;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;

    if (Reset) begin
      w_pc_we      = 1'b0;
      w_ifid_we    = 1'b0;
      w_idex_we    = 1'b0;
      w_state_next = S_RUN;
      w_count_next = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (hz.EX_BranchTaken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
          end else if (hz.EX_MulDivStart) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_we     = 1'b0;
            w_exmem_flush = 1'b1;
            w_state_next  = S_MULDIV;
            w_count_next  = c_CNT_INIT;
          end else if (w_load_use) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
          end else if (hz.ID_Jump) begin
            w_ifid_flush = 1'b1;
          end
        end

        S_MULDIV: begin
          // EX still holds the MULT/DIV, so branch/start inputs from EX are
          // meaningless here and deliberately not examined.
          if (r_count != '0) begin
            w_pc_we       = 1'b0;
            w_ifid_we     = 1'b0;
            w_idex_we     = 1'b0;
            w_exmem_flush = 1'b1;
            w_count_next  = r_count - c_CNT_ONE;
          end else begin
            w_state_next = S_RUN;
            if (w_load_use) begin
              w_pc_we      = 1'b0;
              w_ifid_we    = 1'b0;
              w_idex_flush = 1'b1;
            end else if (hz.ID_Jump) begin
              w_ifid_flush = 1'b1;
            end
          end
        end

        default: begin
          w_state_next = S_RUN;
          w_count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall_cycles <= '0;
    end else if (!w_pc_we && (r_stall_cycles != c_STALL_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign hz.PC_WriteEnable   = w_pc_we;
  assign hz.IFID_WriteEnable = w_ifid_we;
  assign hz.IFID_Flush       = w_ifid_flush;
  assign hz.IDEX_WriteEnable = w_idex_we;
  assign hz.IDEX_Flush       = w_idex_flush;
  assign hz.EXMEM_Flush      = w_exmem_flush;
  assign hz.Busy             = (r_state == S_MULDIV) && !Reset;
  assign hz.StallCycles      = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Directed self-checking bench for pipeline_hazard_ctrl with
//             MULDIV_CYCLES=4. Control outputs are compared as one packed
//             vector {PC_WE, IFID_WE, IFID_Flush, IDEX_WE, IDEX_Flush,
//             EXMEM_Flush, Busy}.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;
  logic [15:0] exp_stall;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MULDIV_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .hz    (hz.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic [6:0] ctl;
  assign ctl = {hz.PC_WriteEnable, hz.IFID_WriteEnable, hz.IFID_Flush,
                hz.IDEX_WriteEnable, hz.IDEX_Flush, hz.EXMEM_Flush, hz.Busy};

  localparam logic [6:0] c_RST     = 7'b0000000;
  localparam logic [6:0] c_IDLE    = 7'b1101000;
  localparam logic [6:0] c_LU      = 7'b0001100;
  localparam logic [6:0] c_FRZ     = 7'b0000010;
  localparam logic [6:0] c_FRZ_B   = 7'b0000011;
  localparam logic [6:0] c_REL     = 7'b1101001;
  localparam logic [6:0] c_REL_LU  = 7'b0001101;
  localparam logic [6:0] c_BRANCH  = 7'b1111100;
  localparam logic [6:0] c_JUMP    = 7'b1111000;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    hz.IFID_Rs = 5'd0; hz.IFID_Rt = 5'd0; hz.IFID_UsesRt = 1'b0;
    hz.IDEX_MemRead = 1'b0; hz.IDEX_Rt = 5'd0; hz.ID_Jump = 1'b0;
    hz.EX_BranchTaken = 1'b0; hz.EX_MulDivStart = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rt, input logic [4:0] rs);
    hz.IDEX_MemRead = 1'b1; hz.IDEX_Rt = rt; hz.IFID_Rs = rs;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (ctl !== c_RST) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, c_RST); end
    Reset = 1'b0;
    tick();
    #1;
    checks++;
    if (ctl !== c_IDLE) begin errors++; $display("FAIL idle_ctl got %b exp %b", ctl, c_IDLE); end
    checks++;
    if (hz.StallCycles !== 16'd0) begin errors++; $display("FAIL idle_stall got %0d exp 0", hz.StallCycles); end
    exp_stall = 16'd0;
  endtask

  task automatic test_load_use();
    set_load_use(5'd8, 5'd8);
    #1;
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL lu_ctl got %b exp %b", ctl, c_LU); end
    tick();
    idle_inputs();
    #1;
    exp_stall = exp_stall + 16'd1;
    checks++;
    if (ctl !== c_IDLE) begin errors++; $display("FAIL lu_after_ctl got %b exp %b", ctl, c_IDLE); end
    checks++;
    if (hz.StallCycles !== exp_stall) begin errors++; $display("FAIL lu_stall got %0d exp %0d", hz.StallCycles, exp_stall); end
    // Load into $zero: no hazard.
    set_load_use(5'd0, 5'd0);
    #1;
    checks++;
    if (ctl !== c_IDLE) begin errors++; $display("FAIL lu_r0_ctl got %b exp %b", ctl, c_IDLE); end
    tick();
    // Rt match only counts when the ID instruction reads Rt.
    hz.IDEX_Rt = 5'd9; hz.IFID_Rs = 5'd3; hz.IFID_Rt = 5'd9; hz.IFID_UsesRt = 1'b0;
    #1;
    checks++;
    if (ctl !== c_IDLE) begin errors++; $display("FAIL lu_rt_unused got %b exp %b", ctl, c_IDLE); end
    hz.IFID_UsesRt = 1'b1;
    #1;
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL lu_rt_used got %b exp %b", ctl, c_LU); end
    tick();
    idle_inputs();
    exp_stall = exp_stall + 16'd1;
    #1;
    checks++;
    if (hz.StallCycles !== exp_stall) begin errors++; $display("FAIL lu_rt_stall got %0d exp %0d", hz.StallCycles, exp_stall); end
  endtask

  task automatic test_muldiv();
    logic [6:0] exp_seq [4];
    exp_seq[0] = c_FRZ; exp_seq[1] = c_FRZ_B; exp_seq[2] = c_FRZ_B; exp_seq[3] = c_REL;
    hz.EX_MulDivStart = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl !== exp_seq[i]) begin errors++; $display("FAIL muldiv_cyc%0d got %b exp %b", i + 1, ctl, exp_seq[i]); end
      tick();
    end
    hz.EX_MulDivStart = 1'b0;
    exp_stall = exp_stall + 16'd3;
    #1;
    checks++;
    if (ctl !== c_IDLE) begin errors++; $display("FAIL muldiv_after got %b exp %b", ctl, c_IDLE); end
    checks++;
    if (hz.StallCycles !== exp_stall) begin errors++; $display("FAIL muldiv_stall got %0d exp %0d", hz.StallCycles, exp_stall); end
  endtask

  task automatic test_muldiv_ignore();
    hz.EX_MulDivStart = 1'b1;
    tick();
    hz.EX_MulDivStart = 1'b0;
    hz.EX_BranchTaken = 1'b1;
    #1;
    checks++;
    if (ctl !== c_FRZ_B) begin errors++; $display("FAIL md_branch_ign got %b exp %b", ctl, c_FRZ_B); end
    tick();
    tick();
    hz.EX_BranchTaken = 1'b0;
    set_load_use(5'd5, 5'd5);
    #1;
    checks++;
    if (ctl !== c_REL_LU) begin errors++; $display("FAIL md_release_lu got %b exp %b", ctl, c_REL_LU); end
    tick();
    idle_inputs();
    exp_stall = exp_stall + 16'd4;
    #1;
    checks++;
    if (hz.StallCycles !== exp_stall) begin errors++; $display("FAIL md_lu_stall got %0d exp %0d", hz.StallCycles, exp_stall); end
  endtask

  task automatic test_branch();
    set_load_use(5'd8, 5'd8);
    hz.ID_Jump = 1'b1;
    hz.EX_BranchTaken = 1'b1;
    hz.EX_MulDivStart = 1'b1;
    #1;
    checks++;
    if (ctl !== c_BRANCH) begin errors++; $display("FAIL branch_ctl got %b exp %b", ctl, c_BRANCH); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (ctl !== c_IDLE) begin errors++; $display("FAIL branch_no_muldiv got %b exp %b", ctl, c_IDLE); end
    checks++;
    if (hz.StallCycles !== exp_stall) begin errors++; $display("FAIL branch_stall got %0d exp %0d", hz.StallCycles, exp_stall); end
  endtask

  task automatic test_jump_load_use();
    set_load_use(5'd12, 5'd12);
    hz.ID_Jump = 1'b1;
    #1;
    checks++;
    if (ctl !== c_LU) begin errors++; $display("FAIL jump_lu_ctl got %b exp %b", ctl, c_LU); end
    tick();
    hz.IDEX_MemRead = 1'b0;
    exp_stall = exp_stall + 16'd1;
    #1;
    checks++;
    if (ctl !== c_JUMP) begin errors++; $display("FAIL jump_next_ctl got %b exp %b", ctl, c_JUMP); end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (hz.StallCycles !== exp_stall) begin errors++; $display("FAIL jump_stall got %0d exp %0d", hz.StallCycles, exp_stall); end
  endtask

  task automatic test_reset_mid_muldiv();
    hz.EX_MulDivStart = 1'b1;
    tick();
    hz.EX_MulDivStart = 1'b0;
    Reset = 1'b1;
    #1;
    checks++;
    if (ctl !== c_RST) begin errors++; $display("FAIL rst_md_ctl got %b exp %b", ctl, c_RST); end
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (ctl !== c_IDLE) begin errors++; $display("FAIL rst_md_after got %b exp %b", ctl, c_IDLE); end
    checks++;
    if (hz.StallCycles !== 16'd0) begin errors++; $display("FAIL rst_md_stall got %0d exp 0", hz.StallCycles); end
    exp_stall = 16'd0;
  endtask

  task automatic test_saturate();
    set_load_use(5'd7, 5'd7);
    for (int i = 0; i < 70000; i++) tick();
    checks++;
    if (hz.StallCycles !== 16'hFFFF) begin errors++; $display("FAIL sat_value got %h exp ffff", hz.StallCycles); end
    tick();
    checks++;
    if (hz.StallCycles !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", hz.StallCycles); end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 16'd0;
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_muldiv();
    test_muldiv_ignore();
    test_branch();
    test_jump_load_use();
    test_reset_mid_muldiv();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
